ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction-fetch front end that drives the instruction memory's `pc`/`stall` request side and consumes its registered `inst`/`done` response.
- Generates sequential fetch addresses, tracks the one in-flight request, buffers returned instructions in a small FIFO, and presents {pc, inst} to decode over a valid/ready handshake.
- Accepts branch/jump redirects that flush all buffered and in-flight work.

Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset.
- PC_INC, 1: address increment per fetch. Imem is word-addressed, so the default is 1.
- FIFO_DEPTH, 2: instruction buffer entries; must be at least 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_pc  output  32  fetch address presented to imem.
- imem_stall  output  1  1 = imem holds its output; 0 = imem samples imem_pc at this edge.
- imem_inst  input  32  imem registered data, valid the cycle after the issue edge.
- imem_done  input  1  imem response valid qualifier.
- redirect_valid  input  1  branch/jump redirect strobe.
- redirect_pc  input  32  redirect target.
- out_valid  output  1  decode-side valid.
- out_pc  output  32  pc of the presented instruction.
- out_inst  output  32  presented instruction.
- out_ready  input  1  decode accepts when out_valid && out_ready.

Behaviour:
- Reset state:
  - fetch_pc=RESET_PC, FIFO count=0, inflight=0.
  - out_valid=0, out_pc=0, out_inst=0, imem_stall=1 during any cycle in which reset=1.
- Reset mid-operation discards all FIFO contents and the in-flight request. No handshake completes in a reset cycle.
- imem_pc = fetch_pc (combinational from the register).
- Issue:
  - Defined as imem_stall=0 in cycle N. imem latches memory[imem_pc] at the end of N.
  - At that same edge: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_INC (mod 2^32, wraps silently).
- Capture: in cycle N+1, if inflight && imem_done, push {inflight_pc, imem_inst} into the FIFO at the edge and clear inflight, unless a new issue sets it again.
- imem_done=0 with inflight=1:
  - imem_stall is forced to 1.
  - inflight holds and capture is retried every cycle until done=1.
- Issue condition, all of the following true:
  - reset=0 and redirect_valid=0.
  - Not (inflight && !imem_done).
  - count + inflight - pop < FIFO_DEPTH, where pop = out_valid && out_ready in the same cycle.
  - Otherwise imem_stall=1.
- Throughput: sustained one instruction per cycle when out_ready=1. Zero-bubble at FIFO_DEPTH=2.
- Output side:
  - out_valid = (count != 0) && !redirect_valid.
  - out_pc/out_inst come from the FIFO head; they hold stable while out_valid && !out_ready.
  - Simultaneous push and pop at full depth is legal; count is unchanged.
- Redirect (cycle R) has priority over everything except reset:
  - FIFO flushed, inflight cleared. A response arriving in R is discarded.
  - fetch_pc<=redirect_pc. No issue and no pop in R.
  - R+1: issue redirect_pc. R+3: out_valid=1, out_pc=redirect_pc.
  - Back-to-back redirects: the last one wins.
- Latency from first post-reset cycle C0:
  - C0 issues RESET_PC.
  - out_valid=1 with out_pc=RESET_PC in C0+2.
- FIFO overflow/underflow is impossible by construction. Pushing into a full FIFO is an assertion failure in simulation.

Optional Feature:
- IFETCH_PERF_EN defined: adds two output ports.
  - perf_fetched, 32 bits: increments on each out handshake.
  - perf_bubbles, 32 bits: increments each non-reset cycle with out_valid=0.
  - Both reset to 0, clear on reset, and wrap at 2^32.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then out_ready=1 and imem_done=1 with memory[k]=k+0x100:
  - Cycle C0+2 shows out_pc=0, out_inst=0x100.
  - Cycles C0+2 through C0+9 show out_pc=0..7 on consecutive cycles with no bubbles.
- Backpressure, out_ready=0 for 5 cycles mid-stream:
  - imem_stall=1 once count=FIFO_DEPTH.
  - out_pc/out_inst hold.
  - After release, delivery resumes in order with no dropped or duplicated pc.
- Redirect with redirect_pc=0x40 while the FIFO is full and a request is in flight:
  - out_valid=0 in R and R+1..R+2.
  - R+1 has imem_pc=0x40, imem_stall=0.
  - R+3 shows out_pc=0x40.
  - No stale pc is ever delivered.
- imem_done=0 for 3 cycles with inflight=1:
  - imem_stall stays 1.
  - fetch_pc is frozen.
  - The instruction is captured on the first done=1 cycle.
- Reset asserted for one cycle mid-stream:
  - Next cycle out_valid=0 and imem_pc=RESET_PC with stall=0.
  - Stream restarts from RESET_PC.
- Redirect to 32'hFFFF_FFFF:
  - Delivered pcs are FFFF_FFFF, 0000_0000, 0000_0001 (wrap).
  - With IFETCH_PERF_EN, perf_fetched equals the handshake count.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: sequential PC generation, one in-flight imem request, small return buffer.
// Define IFETCH_PERF_EN to add the perf_fetched / perf_bubbles counter ports.

module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Push into a full buffer is only legal alongside a pop.
      assert (!(push && !pop && (count == CW'(DEPTH))));
      assert (!(pop && (count == '0)));
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PC_INC     = 32'd1,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  output logic        imem_stall,
  input  logic [31:0] imem_inst,
  input  logic        imem_done,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;

  if (FIFO_DEPTH < 2) begin : g_depth_check
    $error("ifetch_unit: FIFO_DEPTH must be at least 2");
  end

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [63:0]   head_dat;
  logic          wait_resp;
  logic          head_vld;
  logic          pop;
  logic          issue;
  logic          capture;
  logic [OW-1:0] occupancy;
  logic [OW-1:0] limit;

  always_comb begin
    wait_resp = inflight && !imem_done;
    head_vld  = (count != '0) && !redirect_valid && !reset;
    pop       = head_vld && out_ready;
    // Reserve a slot for the in-flight response; a same-cycle pop frees one.
    occupancy = {1'b0, count} + OW'(inflight);
    limit     = OW'(FIFO_DEPTH) + OW'(pop);
    issue     = !reset && !redirect_valid && !wait_resp && (occupancy < limit);
    capture   = inflight && imem_done && !redirect_valid && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc    <= fetch_pc + PC_INC;
      inflight_pc <= fetch_pc;
      inflight    <= 1'b1;
    end else if (capture) begin
      inflight <= 1'b0;
    end
  end

  ifetch_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (capture),
    .push_dat ({inflight_pc, imem_inst}),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  assign imem_pc    = fetch_pc;
  assign imem_stall = !issue;
  assign out_valid  = head_vld;
  assign out_pc     = reset ? '0 : head_dat[63:32];
  assign out_inst   = reset ? '0 : head_dat[31:0];

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (!head_vld) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule
